// File: rtl/cpu_trace_emitter_if.sv
// Request and character-stream bundle for cpu_trace_emitter.
// The master is the CPU commit side and the slave is the emitter.
interface cpu_trace_emitter_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_kind;
  logic [15:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_reg;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        frame_done;

  modport master (
    output in_valid, in_kind, in_time, in_pc, in_reg, in_addr, in_data,
    input  in_ready, char_data, char_valid, frame_done
  );

  modport slave (
    input  in_valid, in_kind, in_time, in_pc, in_reg, in_addr, in_data,
    output in_ready, char_data, char_valid, frame_done
  );
endinterface

// File: rtl/cpu_trace_emitter.sv
// Serialises one write-back record into an ASCII trace line, one char per clock.
// Define TRACE_SPACE_EN to emit ": " and " <= " instead of ":" and "<=".
module cpu_trace_emitter (
  input  logic                  clk,
  input  logic                  reset,
  cpu_trace_emitter_if.slave    bus
);

`ifdef TRACE_SPACE_EN
  localparam logic SPACE_EN = 1'b1;
`else
  localparam logic SPACE_EN = 1'b0;
`endif
  localparam logic [3:0] ARROW_LAST = SPACE_EN ? 4'd3 : 4'd1;

  typedef enum logic [3:0] {
    S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON,
    S_TAG, S_REGNUM, S_ADDR, S_ARROW, S_DATA, S_HASH
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_kind;
  logic [15:0] r_time;
  logic [31:0] r_pc;
  logic [4:0]  r_reg;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [7:0]  r_char;
  logic        r_valid;
  logic        r_done;
  logic        w_ready;

  function automatic logic [7:0] hex_chr(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // BCD digits above 9 are clamped rather than printed as garbage.
  function automatic logic [7:0] bcd_chr(input logic [3:0] n);
    return (n > 4'd9) ? 8'h39 : (8'h30 + {4'h0, n});
  endfunction

  function automatic logic [3:0] nib32(input logic [31:0] w, input logic [2:0] i);
    return 4'(w >> {3'd7 - i, 2'b00});
  endfunction

  function automatic logic [3:0] nib16(input logic [15:0] w, input logic [1:0] i);
    return 4'(w >> {2'd3 - i, 2'b00});
  endfunction

  function automatic logic [1:0] lead_idx(input logic [15:0] t);
    if (t[15:12] != 4'h0)     return 2'd0;
    else if (t[11:8] != 4'h0) return 2'd1;
    else if (t[7:4] != 4'h0)  return 2'd2;
    else                      return 2'd3;
  endfunction

  function automatic logic [3:0] reg_tens(input logic [4:0] r);
    if (r >= 5'd30)      return 4'd3;
    else if (r >= 5'd20) return 4'd2;
    else if (r >= 5'd10) return 4'd1;
    else                 return 4'd0;
  endfunction

  function automatic logic [3:0] reg_units(input logic [4:0] r);
    if (r >= 5'd30)      return 4'(r - 5'd30);
    else if (r >= 5'd20) return 4'(r - 5'd20);
    else if (r >= 5'd10) return 4'(r - 5'd10);
    else                 return 4'(r);
  endfunction

  function automatic logic [7:0] arrow_chr(input logic [3:0] c);
    if (SPACE_EN) begin
      case (c)
        4'd1:    return 8'h3c;
        4'd2:    return 8'h3d;
        default: return 8'h20;
      endcase
    end else begin
      return (c == 4'd0) ? 8'h3c : 8'h3d;
    end
  endfunction

  assign w_ready        = (r_state == S_IDLE);
  assign bus.in_ready   = w_ready;
  assign bus.char_data  = r_char;
  assign bus.char_valid = r_valid;
  assign bus.frame_done = r_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_kind  <= 1'b0;
      r_time  <= 16'h0;
      r_pc    <= 32'h0;
      r_reg   <= 5'd0;
      r_addr  <= 32'h0;
      r_data  <= 32'h0;
      r_char  <= 8'h00;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= 1'b1;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_valid <= 1'b0;
          r_char  <= 8'h00;
          if (bus.in_valid) begin
            r_kind  <= bus.in_kind;
            r_time  <= bus.in_time;
            r_pc    <= bus.in_pc;
            r_reg   <= bus.in_reg;
            r_addr  <= bus.in_addr;
            r_data  <= bus.in_data;
            r_state <= S_CARET;
          end
        end
        S_CARET: begin
          r_char  <= 8'h5e;
          r_cnt   <= {2'b00, lead_idx(r_time)};
          r_state <= S_TIME;
        end
        S_TIME: begin
          r_char <= bcd_chr(nib16(r_time, r_cnt[1:0]));
          if (r_cnt == 4'd3) begin
            r_cnt   <= 4'd0;
            r_state <= S_AT;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_AT: begin
          r_char  <= 8'h40;
          r_cnt   <= 4'd0;
          r_state <= S_PC;
        end
        S_PC: begin
          r_char <= hex_chr(nib32(r_pc, r_cnt[2:0]));
          if (r_cnt == 4'd7) begin
            r_cnt   <= 4'd0;
            r_state <= S_COLON;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_COLON: begin
          r_char <= (r_cnt == 4'd0) ? 8'h3a : 8'h20;
          if (SPACE_EN && r_cnt == 4'd0) begin
            r_cnt <= 4'd1;
          end else begin
            r_cnt   <= 4'd0;
            r_state <= S_TAG;
          end
        end
        S_TAG: begin
          r_char <= r_kind ? 8'h2a : 8'h24;
          if (r_kind) begin
            r_cnt   <= 4'd0;
            r_state <= S_ADDR;
          end else begin
            // Single-digit registers skip straight to the units position.
            r_cnt   <= (r_reg >= 5'd10) ? 4'd0 : 4'd1;
            r_state <= S_REGNUM;
          end
        end
        S_REGNUM: begin
          if (r_cnt == 4'd0) begin
            r_char <= bcd_chr(reg_tens(r_reg));
            r_cnt  <= 4'd1;
          end else begin
            r_char  <= bcd_chr(reg_units(r_reg));
            r_cnt   <= 4'd0;
            r_state <= S_ARROW;
          end
        end
        S_ADDR: begin
          r_char <= hex_chr(nib32(r_addr, r_cnt[2:0]));
          if (r_cnt == 4'd7) begin
            r_cnt   <= 4'd0;
            r_state <= S_ARROW;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_ARROW: begin
          r_char <= arrow_chr(r_cnt);
          if (r_cnt == ARROW_LAST) begin
            r_cnt   <= 4'd0;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DATA: begin
          r_char <= hex_chr(nib32(r_data, r_cnt[2:0]));
          if (r_cnt == 4'd7) begin
            r_cnt   <= 4'd0;
            r_state <= S_HASH;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_HASH: begin
          r_char  <= 8'h23;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_char  <= 8'h00;
          r_cnt   <= 4'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed and randomized bench for cpu_trace_emitter against a string-level trace model.
module tb_cpu_trace_emitter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cpu_trace_emitter_if bus ();

  cpu_trace_emitter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected trace line built directly from the textual format rules.
  function automatic string model(input logic kind, input logic [15:0] tm,
                                  input logic [31:0] pc, input logic [4:0] rg,
                                  input logic [31:0] addr, input logic [31:0] data);
    string ts;
    string sp;
    string body;
    bit    lead;
    int    d;
    ts = "";
    lead = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      d = int'(tm[4*i +: 4]);
      if (d > 9) d = 9;
      if (d != 0) lead = 1'b0;
      if (!lead) ts = {ts, $sformatf("%0d", d)};
    end
    if (ts.len() == 0) ts = "0";
`ifdef TRACE_SPACE_EN
    sp = " ";
`else
    sp = "";
`endif
    body = kind ? {"*", $sformatf("%08h", addr)} : {"$", $sformatf("%0d", rg)};
    return {"^", ts, "@", $sformatf("%08h", pc), ":", sp, body, sp, "<=", sp,
            $sformatf("%08h", data), "#"};
  endfunction

  task automatic drive(input logic kind, input logic [15:0] tm, input logic [31:0] pc,
                       input logic [4:0] rg, input logic [31:0] addr, input logic [31:0] data);
    bus.in_kind = kind;
    bus.in_time = tm;
    bus.in_pc   = pc;
    bus.in_reg  = rg;
    bus.in_addr = addr;
    bus.in_data = data;
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic start_req(input string tag, input logic hold);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready_wait"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
    chk({tag, " latency_gap"}, 32'(bus.char_valid), 32'd0);
  endtask

  task automatic check_range(input string tag, input string s, input int from, input int upto);
    logic [7:0] e;
    for (int i = from; i <= upto; i++) begin
      @(negedge clk);
      e = 8'(s[i]);
      chk($sformatf("%s char[%0d]", tag, i), 32'(bus.char_data), 32'(e));
      chk($sformatf("%s valid[%0d]", tag, i), 32'(bus.char_valid), 32'd1);
      chk($sformatf("%s done[%0d]", tag, i), 32'(bus.frame_done), 32'(i == s.len() - 1));
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, " idle_valid"}, 32'(bus.char_valid), 32'd0);
    chk({tag, " idle_char"}, 32'(bus.char_data), 32'd0);
    chk({tag, " idle_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, " idle_done"}, 32'(bus.frame_done), 32'd0);
  endtask

  task automatic do_record(input string tag, input logic kind, input logic [15:0] tm,
                           input logic [31:0] pc, input logic [4:0] rg,
                           input logic [31:0] addr, input logic [31:0] data);
    string s;
    s = model(kind, tm, pc, rg, addr, data);
    drive(kind, tm, pc, rg, addr, data);
    start_req(tag, 1'b0);
    check_range(tag, s, 0, s.len() - 1);
    check_idle(tag);
  endtask

  initial begin
    string sa;
    string sb;
    logic [15:0] rt;

    reset = 1'b1;
    bus.in_valid = 1'b0;
    drive(1'b0, 16'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("reset char", 32'(bus.char_data), 32'd0);
    chk("reset valid", 32'(bus.char_valid), 32'd0);
    chk("reset done", 32'(bus.frame_done), 32'd0);
    chk("reset ready", 32'(bus.in_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    do_record("reg5", 1'b0, 16'h0012, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd);
    do_record("mem", 1'b1, 16'h1234, 32'hdeadbeef, 5'd0, 32'h00000010, 32'hffffffff);
    do_record("zero", 1'b0, 16'h0000, 32'h00000004, 5'd0, 32'h0, 32'h00000001);
    do_record("reg31", 1'b0, 16'h00a0, 32'h12345678, 5'd31, 32'h0, 32'h9abcdef0);
    do_record("reg10", 1'b0, 16'h0a05, 32'h0000fffc, 5'd10, 32'h0, 32'h80000000);
    do_record("reg9", 1'b0, 16'ha000, 32'h00400000, 5'd9, 32'h0, 32'h0);
    do_record("reg20", 1'b0, 16'h0001, 32'h00400004, 5'd20, 32'h0, 32'h7fffffff);

    // Back-to-back with in_valid held: B is presented while A is still busy.
    sa = model(1'b0, 16'h0099, 32'h00003004, 5'd7, 32'h0, 32'h01234567);
    sb = model(1'b1, 16'h0100, 32'h00003008, 5'd0, 32'h10010000, 32'h89abcdef);
    drive(1'b0, 16'h0099, 32'h00003004, 5'd7, 32'h0, 32'h01234567);
    start_req("b2b_a", 1'b1);
    drive(1'b1, 16'h0100, 32'h00003008, 5'd0, 32'h10010000, 32'h89abcdef);
    check_range("b2b_a", sa, 0, sa.len() - 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b gap_valid", 32'(bus.char_valid), 32'd0);
    check_range("b2b_b", sb, 0, sb.len() - 1);
    check_idle("b2b_b");

    // A request raised and dropped while busy is neither taken nor queued.
    sa = model(1'b0, 16'h0042, 32'h00003010, 5'd3, 32'h0, 32'hcafef00d);
    drive(1'b0, 16'h0042, 32'h00003010, 5'd3, 32'h0, 32'hcafef00d);
    start_req("ign", 1'b0);
    bus.in_valid = 1'b1;
    drive(1'b1, 16'h9999, 32'hffffffff, 5'd31, 32'hffffffff, 32'hffffffff);
    check_range("ign", sa, 0, 4);
    bus.in_valid = 1'b0;
    check_range("ign", sa, 5, sa.len() - 1);
    repeat (3) check_idle("ign_after");

    // Reset on the 10th char, then reset colliding with a request.
    sa = model(1'b1, 16'h5678, 32'h00003020, 5'd0, 32'h0000abcd, 32'h11111111);
    drive(1'b1, 16'h5678, 32'h00003020, 5'd0, 32'h0000abcd, 32'h11111111);
    start_req("rst", 1'b0);
    check_range("rst", sa, 0, 9);
    reset = 1'b1;
    check_idle("rst_mid");
    bus.in_valid = 1'b1;
    drive(1'b0, 16'h0777, 32'h00003030, 5'd12, 32'h0, 32'h22222222);
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_coll ready", 32'(bus.in_ready), 32'd1);
    check_idle("rst_coll");
    do_record("rst_fresh", 1'b0, 16'h0777, 32'h00003030, 5'd12, 32'h0, 32'h22222222);

    for (int k = 0; k < 25; k++) begin
      rt = 16'($urandom);
      rt = rt >> (4 * $urandom_range(0, 4));
      do_record($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), rt, $urandom,
                5'($urandom_range(0, 31)), $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
